// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and constants for the line memory arbiter.
//  Revision : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    function automatic int line_w(input int line_addr_len);
        return 32 << line_addr_len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Combinational two-requester round-robin chooser.
//  Revision : 1.0
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        case (req)
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_owner;
            default: winner = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/line_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : line_mem_arbiter
//  Purpose  : Round-robin sharing of one line-granular main memory between
//             the instruction cache (port 0) and data cache (port 1).
//  Revision : 1.0
// ============================================================================
module line_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int LINE_ADDR_LEN = 3,
    parameter  int MEM_ADDR_LEN  = 10,
    localparam int LINE_W        = line_w(LINE_ADDR_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    p0_rd_req,
    input  logic                    p0_wr_req,
    input  logic [MEM_ADDR_LEN-1:0] p0_addr,
    input  logic [LINE_W-1:0]       p0_wr_line,
    output logic [LINE_W-1:0]       p0_rd_line,
    output logic                    p0_gnt,
    input  logic                    p1_rd_req,
    input  logic                    p1_wr_req,
    input  logic [MEM_ADDR_LEN-1:0] p1_addr,
    input  logic [LINE_W-1:0]       p1_wr_line,
    output logic [LINE_W-1:0]       p1_rd_line,
    output logic                    p1_gnt,
    output logic                    mem_rd_req,
    output logic                    mem_wr_req,
    output logic [MEM_ADDR_LEN-1:0] mem_addr,
    output logic [LINE_W-1:0]       mem_wr_line,
    input  logic [LINE_W-1:0]       mem_rd_line,
    input  logic                    mem_gnt
);

    arb_state_t              r_state;
    logic                    r_last_owner;
    logic                    r_owner;
    logic                    r_mem_rd_req;
    logic                    r_mem_wr_req;
    logic [MEM_ADDR_LEN-1:0] r_mem_addr;
    logic [LINE_W-1:0]       r_mem_wr_line;
    logic [LINE_W-1:0]       r_p0_rd_line;
    logic [LINE_W-1:0]       r_p1_rd_line;
    logic                    r_p0_gnt;
    logic                    r_p1_gnt;

    logic [1:0]              w_req;
    logic                    w_valid;
    logic                    w_winner;
    logic                    w_op_wr;
    logic [MEM_ADDR_LEN-1:0] w_addr;
    logic [LINE_W-1:0]       w_wr_line;

    assign w_req = {p1_rd_req | p1_wr_req, p0_rd_req | p0_wr_req};

    rr_arb2 u_rr_arb2 (
        .req        (w_req),
        .last_owner (r_last_owner),
        .valid      (w_valid),
        .winner     (w_winner)
    );

    // A port raising both rd and wr gets its write first (write-back before fill).
    assign w_op_wr   = (w_winner == PORT_D) ? p1_wr_req  : p0_wr_req;
    assign w_addr    = (w_winner == PORT_D) ? p1_addr    : p0_addr;
    assign w_wr_line = (w_winner == PORT_D) ? p1_wr_line : p0_wr_line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_owner  <= PORT_D;
            r_owner       <= PORT_I;
            r_mem_rd_req  <= 1'b0;
            r_mem_wr_req  <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wr_line <= '0;
            r_p0_rd_line  <= '0;
            r_p1_rd_line  <= '0;
            r_p0_gnt      <= 1'b0;
            r_p1_gnt      <= 1'b0;
        end else begin
            r_p0_gnt <= 1'b0;
            r_p1_gnt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_owner       <= w_winner;
                        r_mem_rd_req  <= ~w_op_wr;
                        r_mem_wr_req  <= w_op_wr;
                        r_mem_addr    <= w_addr;
                        r_mem_wr_line <= w_op_wr ? w_wr_line : '0;
                        r_state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_gnt) begin
                        r_last_owner  <= r_owner;
                        r_mem_rd_req  <= 1'b0;
                        r_mem_wr_req  <= 1'b0;
                        r_mem_addr    <= '0;
                        r_mem_wr_line <= '0;
                        // r_mem_wr_req still holds the latched op here.
                        if (!r_mem_wr_req) begin
                            if (r_owner == PORT_D) r_p1_rd_line <= mem_rd_line;
                            else                   r_p0_rd_line <= mem_rd_line;
                        end
                        if (r_owner == PORT_D) r_p1_gnt <= 1'b1;
                        else                   r_p0_gnt <= 1'b1;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_rd_req  = r_mem_rd_req;
    assign mem_wr_req  = r_mem_wr_req;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_line = r_mem_wr_line;
    assign p0_rd_line  = r_p0_rd_line;
    assign p1_rd_line  = r_p1_rd_line;
    assign p0_gnt      = r_p0_gnt;
    assign p1_gnt      = r_p1_gnt;

endmodule
`default_nettype wire

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
- Shares one slow line-granularity main memory between two cache requesters: port 0 is the instruction cache, port 1 is the data cache.
- Each cache keeps its swap-in/swap-out sequencing and sees a private memory port with the same rd_req/wr_req/gnt handshake.
- The arbiter serialises transactions with round-robin priority and registers returned lines per port.
- It sits between the two cache instances and the single main_mem instance.

Parameters:
- LINE_ADDR_LEN, 3: log2 words per line; LINE_W = 32 << LINE_ADDR_LEN bits.
- MEM_ADDR_LEN, 10: line address width (tag + set bits).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- p0_rd_req  in  1  port 0 line read request, held until p0_gnt
- p0_wr_req  in  1  port 0 line write request, held until p0_gnt
- p0_addr  in  MEM_ADDR_LEN  port 0 line address
- p0_wr_line  in  LINE_W  port 0 write data, word k at bits [32k+31:32k]
- p0_rd_line  out  LINE_W  port 0 registered read data
- p0_gnt  out  1  port 0 completion pulse
- p1_rd_req, p1_wr_req, p1_addr, p1_wr_line, p1_rd_line, p1_gnt: same as port 0, for port 1
- mem_rd_req  out  1  to main_mem
- mem_wr_req  out  1  to main_mem
- mem_addr  out  MEM_ADDR_LEN  to main_mem
- mem_wr_line  out  LINE_W  to main_mem
- mem_rd_line  in  LINE_W  from main_mem
- mem_gnt  in  1  main_mem completion, one-cycle pulse

Behaviour:
- Reset rst: asynchronous, active-high; clock clk.
- Reset values:
  - All outputs 0; p0_rd_line and p1_rd_line cleared.
  - State IDLE; round-robin pointer last_owner = 1, so port 0 has priority first.
- Port request: req_x = px_rd_req | px_wr_req.
  - If both rd and wr are high on a port, the write is served and the read stays pending. This matches write-back-before-fill ordering.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - If no req_x, stay in IDLE and keep all mem_* low.
  - If exactly one port requests, grant it.
  - If both request, grant the port != last_owner.
  - On grant, latch owner, op (write if wr_req), addr and wr_line into registers, then go to BUSY.
  - Arbitration decision is on the IDLE cycle; mem request appears the next cycle (1-cycle arbitration latency).
- BUSY:
  - mem_rd_req / mem_wr_req per latched op; mem_addr and mem_wr_line come from the latched registers.
  - Request inputs changing during BUSY are ignored.
  - On mem_gnt: set last_owner <= owner. For a read, capture mem_rd_line into the owner's px_rd_line. Then go to RELEASE.
- px_gnt: registered; high for exactly the single cycle after mem_gnt (the RELEASE cycle), owner port only.
  - px_rd_line is valid from that cycle and holds until that port's next completed read. Writes never alter px_rd_line.
- RELEASE:
  - mem_rd_req = mem_wr_req = 0 for this one cycle, so main_mem sees a request drop between transactions.
  - Unconditionally go to IDLE.
- Throughput: the minimum per-transaction overhead is 2 cycles (IDLE + RELEASE) plus main_mem latency.
- Fairness: under continuous requests from both ports, grants strictly alternate. A port waits at most one foreign transaction.
- A requester whose req stays high after its gnt, for example SWAP_OUT then SWAP_IN, is treated as a new request and re-arbitrated.
- mem_gnt outside BUSY is ignored.
- Reset mid-BUSY:
  - Abort immediately; all outputs return to reset values.
  - No px_gnt is issued for the aborted transaction.
- Output invariants:
  - mem_rd_req and mem_wr_req are never high together.
  - p0_gnt and p1_gnt are never high together.
  - mem_addr = 0 when no mem request is active.

Decomposition:
- Shared package mem_arb_pkg: state enum {IDLE, BUSY, RELEASE}, the LINE_W function of LINE_ADDR_LEN, and the port-index constants PORT_I = 0 and PORT_D = 1.
- One natural sub-module: rr_arb2, a combinational 2-input round-robin chooser (inputs req[1:0] and last_owner; outputs valid and winner). It is reusable if more requesters are added later.

Test Plan:
- Single read: p0_rd_req, addr 0x05A, main_mem latency 50 → mem_rd_req high from cycle 1 with mem_addr=0x05A. p0_gnt pulses one cycle after mem_gnt. p0_rd_line equals the memory line; p1_gnt stays 0.
- Write then read on one port: p1_wr_req, addr 0x123, line words 0..7 = 0xA0..0xA7, then p1_rd_req same addr → two transactions separated by a RELEASE cycle with mem req low. The read returns 0xA0..0xA7.
- Contention: p0_rd_req and p1_rd_req asserted together out of reset and held through repeated gnts → grant order 0,1,0,1. No port receives two consecutive gnts.
- Both rd and wr on port 1 (write addr 0x010, read addr 0x010) → write issued first, then read after re-arbitration. p1_rd_line reflects the written data.
- Async reset asserted mid-BUSY for 2 cycles → mem_* and gnts drop to 0 asynchronously and p0/p1_rd_line clear. After release, port 0 wins the first simultaneous request.
- Spurious mem_gnt pulse while IDLE → no px_gnt and no state change.
